// File: rtl/round_robin_arbiter_n_if.sv
// Request/grant bundle between N requesters and a round-robin arbiter.
// master = requester side, slave = arbiter side.
interface round_robin_arbiter_n_if #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
);
  logic [N-1:0]     requests;
  logic [N-1:0]     last;
  logic [N-1:0]     grants;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             locked;

  modport master (
    output requests, last,
    input  grants, grant_valid, grant_idx, locked
  );

  modport slave (
    input  requests, last,
    output grants, grant_valid, grant_idx, locked
  );
endinterface

// File: rtl/round_robin_arbiter_n.sv
// N-way round-robin arbiter with optional hold-until-last packet lock.
// Latency: grants are combinational from requests (zero cycles); state moves on clk.
// Backpressure: a requester simply keeps requests[i] high until granted; a locked owner blocks all others.
module round_robin_arbiter_n #(
  parameter int N       = 4,
  parameter bit LOCK_EN = 1'b0,
  parameter int IDX_W   = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  round_robin_arbiter_n_if.slave bus
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock_q;

  logic [N-1:0]     hi_mask;
  logic [N-1:0]     masked;
  logic [N-1:0]     pick;
  logic [N-1:0]     rr_oh;
  logic [N-1:0]     own_oh;
  logic [N-1:0]     arb;
  logic [N-1:0]     grants_w;
  logic [IDX_W-1:0] gidx;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  assign lock_q = (state == S_LOCKED);

  // Requesters at or above ptr get first pick; if none, fall back to the full
  // vector, which yields the wrap-around search without a barrel rotate.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
  end

  assign masked = bus.requests & hi_mask;
  assign pick   = (|masked) ? masked : bus.requests;
  assign rr_oh  = pick & (~pick + N'(1));
  assign own_oh = N'(1) << lock_idx;
  assign arb    = lock_q ? (bus.requests & own_oh) : rr_oh;

  // Gating with rst keeps outputs quiet for the whole reset window,
  // including the first cycle before any clock edge has cleared state.
  assign grants_w = rst ? arb : '0;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grants_w[i]) begin
        gidx = gidx | IDX_W'(i);
      end
    end
  end

  assign bus.grants      = grants_w;
  assign bus.grant_valid = |grants_w;
  assign bus.grant_idx   = gidx;
  assign bus.locked      = lock_q & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      lock_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grants_w) begin
            if (LOCK_EN && !bus.last[gidx]) begin
              state    <= S_LOCKED;
              lock_idx <= gidx;
            end else begin
              ptr <= nxt(gidx);
            end
          end
        end
        S_LOCKED: begin
          // Owner keeps the lock even while its request is low.
          if (grants_w[lock_idx] && bus.last[lock_idx]) begin
            state <= S_IDLE;
            ptr   <= nxt(lock_idx);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Bench for round_robin_arbiter_n: five instances (N=2/3/4/8, lock on/off) checked every cycle
// against a modulo-search reference model, plus literal grant tables and random fairness checks.
module tb_round_robin_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam int NI = 5;
  int nn[NI]  = '{2, 3, 4, 8, 8};
  bit le[NI]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [31:0] req[NI];
  logic [31:0] lst[NI];
  logic [31:0] gnt[NI];
  logic [31:0] idx[NI];
  logic        vld[NI];
  logic        lck[NI];

  int tests = 0;
  int fails = 0;

  round_robin_arbiter_n_if #(.N(2)) if0 ();
  round_robin_arbiter_n_if #(.N(3)) if1 ();
  round_robin_arbiter_n_if #(.N(4)) if2 ();
  round_robin_arbiter_n_if #(.N(8)) if3 ();
  round_robin_arbiter_n_if #(.N(8)) if4 ();

  round_robin_arbiter_n #(.N(2), .LOCK_EN(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  round_robin_arbiter_n #(.N(3), .LOCK_EN(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  round_robin_arbiter_n #(.N(4), .LOCK_EN(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  round_robin_arbiter_n #(.N(8), .LOCK_EN(1'b1)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  round_robin_arbiter_n #(.N(8), .LOCK_EN(1'b0)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  assign if0.requests = req[0][1:0];  assign if0.last = lst[0][1:0];
  assign if1.requests = req[1][2:0];  assign if1.last = lst[1][2:0];
  assign if2.requests = req[2][3:0];  assign if2.last = lst[2][3:0];
  assign if3.requests = req[3][7:0];  assign if3.last = lst[3][7:0];
  assign if4.requests = req[4][7:0];  assign if4.last = lst[4][7:0];

  assign gnt[0] = 32'(if0.grants); assign idx[0] = 32'(if0.grant_idx);
  assign gnt[1] = 32'(if1.grants); assign idx[1] = 32'(if1.grant_idx);
  assign gnt[2] = 32'(if2.grants); assign idx[2] = 32'(if2.grant_idx);
  assign gnt[3] = 32'(if3.grants); assign idx[3] = 32'(if3.grant_idx);
  assign gnt[4] = 32'(if4.grants); assign idx[4] = 32'(if4.grant_idx);
  assign vld[0] = if0.grant_valid; assign lck[0] = if0.locked;
  assign vld[1] = if1.grant_valid; assign lck[1] = if1.locked;
  assign vld[2] = if2.grant_valid; assign lck[2] = if2.locked;
  assign vld[3] = if3.grant_valid; assign lck[3] = if3.locked;
  assign vld[4] = if4.grant_valid; assign lck[4] = if4.locked;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: priority pointer, lock flag and lock owner per instance.
  int m_ptr[NI];
  bit m_lock[NI];
  int m_own[NI];

  function automatic int model_grant(input int k);
    if (rst !== 1'b1) return -1;
    if (m_lock[k]) return req[k][m_own[k]] ? m_own[k] : -1;
    for (int off = 0; off < nn[k]; off++) begin
      if (req[k][(m_ptr[k] + off) % nn[k]]) return (m_ptr[k] + off) % nn[k];
    end
    return -1;
  endfunction

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_ptr[k] = 0; m_lock[k] = 1'b0; m_own[k] = 0;
      req[k] = '0; lst[k] = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      automatic int g = model_grant(k);
      if (rst !== 1'b1) begin
        m_ptr[k] = 0; m_lock[k] = 1'b0; m_own[k] = 0;
      end else if (m_lock[k]) begin
        if (g >= 0 && lst[k][g]) begin
          m_lock[k] = 1'b0;
          m_ptr[k]  = (g + 1) % nn[k];
        end
      end else if (g >= 0) begin
        if (le[k] && !lst[k][g]) begin
          m_lock[k] = 1'b1;
          m_own[k]  = g;
        end else begin
          m_ptr[k] = (g + 1) % nn[k];
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus structural and fairness checks.
  int waitc[8];
  initial for (int i = 0; i < 8; i++) waitc[i] = 0;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      automatic int g = model_grant(k);
      automatic logic [31:0] eg = (g < 0) ? 32'd0 : (32'd1 << g);
      chk("model_grants", k, gnt[k], eg);
      chk("model_valid", k, 32'(vld[k]), (g < 0) ? 32'd0 : 32'd1);
      chk("model_idx", k, idx[k], (g < 0) ? 32'd0 : 32'(g));
      chk("model_locked", k, 32'(lck[k]), 32'((rst === 1'b1) && m_lock[k]));
    end
    for (int k = 3; k < NI; k++) begin
      chk("onehot0", k, 32'($onehot0(gnt[k])), 32'd1);
      chk("subset", k, gnt[k] & ~req[k], 32'd0);
    end
    if (rst === 1'b1 && gnt[4] != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (req[4][i] && !gnt[4][i]) begin
          waitc[i]++;
          chk("starve", i, 32'(waitc[i] <= 7), 32'd1);
        end else begin
          waitc[i] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) if (!req[4][i]) waitc[i] = 0;
    end
  end

  logic [1:0] t1_req[10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
  logic [1:0] t1_g[10]   = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};

  logic [3:0] t3_req[16]  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hB, 4'hB,
                              4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0] t3_last[16] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h2, 4'h0, 4'h0,
                              4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
  logic [3:0] t3_g[16]    = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0,
                              4'h4, 4'h4, 4'h8, 4'h8, 4'h0, 4'h0, 4'h1, 4'h2};
  bit         t3_l[16]    = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0};
  bit         t3_rst[16]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < NI; k++) req[k] = '1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_grants", k, gnt[k], 32'd0);
      chk("rst_locked", k, 32'(lck[k]), 32'd0);
    end
    cyc();
    cyc();
    for (int k = 0; k < NI; k++) req[k] = '0;
    rst = 1'b1;

    // N=2 alternating pattern
    for (int c = 0; c < 10; c++) begin
      req[0] = 32'(t1_req[c]);
      @(negedge clk);
      chk("n2_grants", 0, gnt[0], 32'(t1_g[c]));
      cyc();
    end
    req[0] = '0;

    // N=3 full load: pointer wraps 2 -> 0
    for (int c = 0; c < 6; c++) begin
      req[1] = 32'h7;
      @(negedge clk);
      chk("n3_grants", 1, gnt[1], 32'd1 << (c % 3));
      chk("n3_idx", 1, idx[1], 32'(c % 3));
      cyc();
    end
    req[1] = '0;

    // N=4 lock: hold to last, owner drop, lock to 3, reset mid-lock
    for (int c = 0; c < 16; c++) begin
      req[2] = 32'(t3_req[c]);
      lst[2] = 32'(t3_last[c]);
      rst    = t3_rst[c];
      @(negedge clk);
      chk("n4_grants", 2, gnt[2], 32'(t3_g[c]));
      chk("n4_locked", 2, 32'(lck[2]), 32'(t3_l[c]));
      cyc();
    end
    req[2] = '0;
    lst[2] = '0;

    // N=8 random traffic, lock on and off
    for (int c = 0; c < 10000; c++) begin
      req[3] = 32'($urandom_range(0, 255));
      lst[3] = 32'($urandom_range(0, 255) & $urandom_range(0, 255));
      req[4] = 32'($urandom_range(0, 255) | $urandom_range(0, 255));
      lst[4] = 32'($urandom_range(0, 255));
      cyc();
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_n.md
# round_robin_arbiter_n

Parametrised N-requester round-robin arbiter with optional packet lock. Each cycle it grants at most one requester, one-hot, rotating priority so every persistently asserted requester is served within N grants. With locking enabled, a granted requester keeps the grant until it signals the end of its transfer. It sits in front of shared resources (bus ports, shared FIFOs, memory ports) where more than two masters and multi-beat transfers must be arbitrated.

## Interface
- `N`, default 4: number of requesters, legal range 2..32, need not be a power of two.
- `LOCK_EN`, default 0:
  - 0: arbitrate every cycle.
  - 1: hold the grant from the first granted beat until a beat with `last` set.
- `IDX_W`, default `$clog2(N)`: width of index signals. Derived; never overridden.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-low (asserted when 0).
- `requests` in N: request vector, bit i from requester i.
- `last` in N: bit i marks the final beat of requester i's transfer. Ignored when `LOCK_EN`=0.
- `grants` out N: one-hot or all-zero grant vector, combinational from the inputs and the registered state.
- `grant_valid` out 1: OR-reduction of `grants`.
- `grant_idx` out IDX_W: index of the set bit of `grants`; 0 when `grant_valid`=0.
- `locked` out 1: registered; 1 while a lock is held.

## Operation
State registers:
- `ptr` (IDX_W): highest-priority requester index.
- `lock_q` (1): lock held.
- `lock_idx` (IDX_W): owner of the held lock.

Arbitration while `lock_q`=0:
- Search `requests` starting at index `ptr`, ascending, wrapping modulo N.
- The first set bit wins.
- No bits set gives `grants`=0.

Arbitration while `lock_q`=1:
- `grants` = onehot(`lock_idx`) if `requests[lock_idx]`=1, otherwise 0.
- All other requesters are blocked.

Pointer update, on any cycle with a grant to index g that does not create or keep a lock:
- `ptr` <= g+1, or 0 when g = N-1.
- No grant leaves `ptr` unchanged.

Lock FSM (only when `LOCK_EN`=1):
- IDLE -> LOCKED when a grant to g occurs with `last[g]`=0. Set `lock_idx`<=g; `ptr` unchanged.
- LOCKED -> LOCKED while no beat with `grants[lock_idx]` & `last[lock_idx]` occurs. If the owner drops its request, it still holds the lock and the grant is 0 that cycle.
- LOCKED -> IDLE on `grants[lock_idx]` & `last[lock_idx]`. Set `ptr` <= `lock_idx`+1 mod N.
- A grant with `last[g]`=1 while IDLE is a single-beat transfer: no lock is taken and `ptr` advances normally.

With `LOCK_EN`=0, `lock_q` stays 0 and `locked` stays 0.

During reset (`rst`=0):
- `grants`=0, `grant_valid`=0, `grant_idx`=0, `locked`=0.
- `ptr` <= 0, `lock_q` <= 0, `lock_idx` <= 0.
- Reset asserted mid-lock drops the lock.

## Timing
- Grant latency is zero: `grants` responds combinationally to `requests` in the same cycle.
- State updates take effect on the next rising edge.
- First cycle after reset release: priority order is 0, 1, …, N-1.
- Fairness: a continuously asserted request is granted within N grant cycles when `LOCK_EN`=0. With locking, the wait is additionally bounded by the other requesters' transfer lengths.
- Boundary cases:
  - `ptr` wraps from N-1 to 0 (also for non-power-of-two N, e.g. N=3: 2 -> 0).
  - All requests set: grants rotate strictly i, i+1, …
  - A single requester repeatedly asserting gets granted every cycle.
- `grants` is never multi-hot, including in the cycle `rst` deasserts.

## Test plan
- N=2, `LOCK_EN`=0, `requests` sequence 01 00 10 11 11 00 11 00 11 11 -> `grants` 01 00 10 01 10 00 01 00 10 01.
- N=3, `LOCK_EN`=0, `requests`=111 held for 6 cycles -> `grants` 001 010 100 001 010 100, with `grant_idx` 0 1 2 0 1 2 (wrap at non-power-of-two).
- N=4, `LOCK_EN`=1:
  - Stimulus: `requests`=1111 for 6 cycles; `last[0]` set only in cycle 3; `last[1]` set from cycle 4 on.
  - Required response: `grants`=0001 in cycles 0–3 and `locked`=1 in cycles 1–3; cycle 4 `grants`=0010 and `locked`=0 in cycle 5; cycle 5 `grants`=0100.
- N=4, `LOCK_EN`=1:
  - Stimulus: owner 2 locks, then drops `requests[2]` for 2 cycles while `requests`=1011.
  - Required response: `grants`=0000 for those 2 cycles and `locked` stays 1; `grants`=0100 when `requests[2]` returns.
- Reset mid-lock: pull `rst` low while locked to 3 -> `grants`=0 and `locked`=0 during reset; after release, `requests`=1111 with `last`=1111 gives first grant 0001.
- N=8, random `requests`/`last` for 10k cycles with assertions:
  - `grants` one-hot or zero.
  - `grants` is a subset of `requests`.
  - No starvation beyond the bound above.
